// File: rtl/i2c_target.sv
// Single-address I2C target over an 8-entry byte register space, oversampled on i2c_clock.
// Writes leave as one-cycle strobes; reads come back through a combinational lookup port.
module i2c_target #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_clock,
  input  logic       reset,
  input  logic [6:0] deviceAddr,
  input  logic       SCLpin,
  inout  wire        SDApin,
  output logic       wrValid,
  output logic [2:0] wrAddr,
  output logic [7:0] wrData,
  output logic [2:0] rdAddr,
  input  logic [7:0] rdData,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_r, sda_r, scl_prev, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_q;
  logic [3:0] cnt_q;
  logic       ack_q;
  logic [2:0] rd_addr_q, wr_addr_q;
  logic [7:0] wr_data_q;
  logic       wr_valid_q;
  logic       sda_low;
  logic       addr_match;

  // Reset preloads the chains with the live pins so release never fakes an edge.
  always_ff @(posedge i2c_clock) begin
    if (reset) begin
      scl_sync <= {SYNC_STAGES{SCLpin}};
      sda_sync <= {SYNC_STAGES{SDApin}};
      scl_prev <= SCLpin;
      sda_prev <= SDApin;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCLpin};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDApin};
      scl_prev <= scl_r;
      sda_prev <= sda_r;
    end
  end

  assign scl_r    = scl_sync[SYNC_STAGES-1];
  assign sda_r    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_r & ~scl_prev;
  assign scl_fall = ~scl_r & scl_prev;
  // SCL must be stable high across the SDA change; a simultaneous change is a data bit.
  assign start_det  = scl_r & scl_prev & sda_prev & ~sda_r;
  assign stop_det   = scl_r & scl_prev & ~sda_prev & sda_r;
  assign addr_match = (shift_q[7:1] == deviceAddr);

  always_ff @(posedge i2c_clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = StIdle;
    end else if (start_det) begin
      state_d = StAddr;
    end else if (scl_fall) begin
      case (state_q)
        StAddr:     if (cnt_q == 4'd8) state_d = addr_match ? StAddrAck : StIdle;
        StAddrAck:  state_d = shift_q[0] ? StRdata : StReg;
        StReg:      if (cnt_q == 4'd8) state_d = StRegAck;
        StRegAck:   state_d = StWdata;
        StWdata:    if (cnt_q == 4'd8) state_d = StWdataAck;
        StWdataAck: state_d = StWdata;
        StRdata:    if (cnt_q == 4'd7) state_d = StRdataAck;
        StRdataAck: state_d = ack_q ? StIdle : StRdata;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_low = 1'b0;
    busy    = 1'b1;
    case (state_q)
      StIdle, StAddr:                    busy    = 1'b0;
      StAddrAck, StRegAck, StWdataAck:   sda_low = 1'b1;
      StRdata:                           sda_low = ~shift_q[7];
      default:                           sda_low = 1'b0;
    endcase
  end

  assign SDApin = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge i2c_clock) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b1;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det || stop_det) begin
        cnt_q <= '0;
      end else if (scl_rise) begin
        if (state_q inside {StAddr, StReg, StWdata}) begin
          shift_q <= {shift_q[6:0], sda_r};
          cnt_q   <= cnt_q + 4'd1;
        end else if (state_q == StRdataAck) begin
          ack_q <= sda_r;
          if (!sda_r) rd_addr_q <= rd_addr_q + 3'd1;
        end
      end else if (scl_fall) begin
        case (state_q)
          StAddrAck: begin
            cnt_q <= '0;
            if (shift_q[0]) shift_q <= rdData;
          end
          StReg: begin
            if (cnt_q == 4'd8) begin
              rd_addr_q <= shift_q[2:0];
              cnt_q     <= '0;
            end
          end
          StWdata: begin
            if (cnt_q == 4'd8) begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= rd_addr_q;
              wr_data_q  <= shift_q;
              rd_addr_q  <= rd_addr_q + 3'd1;
              cnt_q      <= '0;
            end
          end
          StRdata: begin
            shift_q <= {shift_q[6:0], 1'b1};
            cnt_q   <= cnt_q + 4'd1;
          end
          StRdataAck: begin
            cnt_q <= '0;
            if (!ack_q) shift_q <= rdData;
          end
          StRegAck, StWdataAck: cnt_q <= '0;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign wrValid = wr_valid_q;
  assign wrAddr  = wr_addr_q;
  assign wrData  = wr_data_q;
  assign rdAddr  = rd_addr_q;

endmodule

// File: doc/i2c_target.md
# i2c_target

Single-address I2C target (responder) that lets an I2C controller on the same bus write and read an 8-entry byte register space. It oversamples SCLpin/SDApin on `i2c_clock`, detects START/STOP, matches the 7-bit address, ACKs, and drives read data open-drain. Register storage lives outside the block: writes leave as one-cycle strobes, reads come back through a combinational lookup port. Used as the bus-side peer for controller bring-up and as a loopback target in lab benches.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on SCLpin and SDApin; minimum 2.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `i2c_clock`  in  1  system oversampling clock; must run at least 8× the SCL frequency.
- `reset`  in  1  synchronous, active-high.
- `deviceAddr`  in  7  target address; compared against the first 7 bits after START.
- `SCLpin`  in  1  bus clock; input only, no clock stretching.
- `SDApin`  inout  1  open-drain: driven `0` or `z`, never `1`.
- `wrValid`  out  1  one-cycle pulse; a byte was written.
- `wrAddr`  out  3  register index for `wrValid`.
- `wrData`  out  8  byte for `wrValid`.
- `rdAddr`  out  3  current register pointer.
- `rdData`  in  8  byte at `rdAddr`; combinational, sampled by the block.
- `busy`  out  1  high from address match until STOP, repeated START, or NACK.

## Operation
- SCLpin and SDApin pass through SYNC_STAGES flops. Edges are detected on the synchronized copies (scl_r, sda_r).
- START: sda_r falls while scl_r is high. STOP: sda_r rises while scl_r is high.
  - START/repeated START in any state clears the bit counter and enters ADDR.
  - STOP in any state enters IDLE.
- Receive bits are sampled on scl_r rising edges, MSB first. Driven SDA changes only on the cycle after an scl_r falling edge.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Mismatch: IDLE, no ACK.
    - Match: ADDR_ACK.
  - ADDR_ACK: drive 0 for the 9th bit.
    - R/W=0: REG.
    - R/W=1: latch rdData into shifter, then RDATA.
  - REG: shift 8 bits. rdAddr ← bits[2:0]; bits[7:3] are ignored. Then REG_ACK (ACK always).
  - REG_ACK: drive 0 for the 9th bit, then WDATA.
  - WDATA: shift 8 bits, then WDATA_ACK.
  - WDATA_ACK: wrValid pulse with wrAddr=rdAddr and wrData=byte. Drive 0. rdAddr increments. Return to WDATA.
  - RDATA: drive shifter MSB first (0 → drive low, 1 → release), then RDATA_ACK.
  - RDATA_ACK: release SDA and sample the controller's bit.
    - ACK(0): rdAddr increments, latch the new rdData, return to RDATA.
    - NACK(1): IDLE.
- rdAddr is 3-bit and wraps 7→0. It persists across transactions and resets to 0.
- A STOP or START arriving mid-byte discards the partial byte. No wrValid, no pointer change.
- Reset at any point: state IDLE, SDA released; the block ignores the bus until the next START.

## Timing
- Reset values: SDApin=z, wrValid=0, wrAddr=0, wrData=0, rdAddr=0, busy=0.
- Edge or START/STOP is recognized SYNC_STAGES+1 cycles after the pin change.
- ACK/data drive is applied within SYNC_STAGES+2 cycles of the SCL pin falling edge and held until the next falling edge of the 9th (or current) bit.
- wrValid asserts the cycle the WDATA_ACK drive begins. wrAddr/wrData are valid that cycle and hold until the next pulse.
- rdData is sampled at the ADDR_ACK→RDATA and RDATA_ACK→RDATA transitions; changes at any other time are ignored.
- busy rises with the ADDR_ACK drive and falls the cycle IDLE/ADDR is entered.
- START and STOP detected on the same cycle cannot occur. If SDA and SCL both change in one synchronized cycle, treat it as a data-bit change, not START/STOP.

## Test plan
- Write: deviceAddr=7'h42; START, 0x84, 0x03, 0xA5, 0x5A, STOP.
  - ACK on all 4 bytes.
  - wrValid pulses with (3,A5) then (4,5A).
  - rdAddr=5 after.
- Combined read: START, 0x84, 0x07, repeated START, 0x85; read 2 bytes (ACK, NACK); rdData=8'hC0|rdAddr.
  - SDA carries C7 then C0 (wrap).
  - Block returns to IDLE after the NACK.
- Mismatch: START, 0x90, 0x01, STOP.
  - SDApin never driven low.
  - wrValid never pulses; busy stays 0.
- Abort: START, 0x84, 0x02, 4 bits of data, STOP.
  - No wrValid; rdAddr=2.
  - The next write transaction works normally.
- Reset mid-ACK: assert reset during ADDR_ACK drive.
  - SDApin = z the next cycle; all outputs at reset values.
  - Bus activity without a new START is ignored.
- Oversampling margin: SCL at 1/8 of i2c_clock, SDA changing 1 cycle after SCL falls.
  - Write and read tests pass with no spurious START/STOP.
